legv8_control_sequencer: RTL and testbench

//  Multi-cycle LEGv8 control unit. It drives the control word of the 64-bit datapath
//  (DA/SA/SB/FS/k/dataMux/regW/ramW/Bsel), replacing bench-driven control words.

---
 rtl/legv8_control_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_legv8_control_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_sequencer.sv
// Multi-cycle LEGv8 control unit: owns PC/IR, sequences FETCH -> EXEC (-> MEM),
// and decodes the datapath control word combinationally from state and IR.
//
// state   | meaning
// FETCH   | latch instruction into IR, record its address, advance pc by 4
// EXEC    | drive control word for IR; branches redirect pc here
// MEM     | second cycle of LDUR: RAM read data written back to Rt
// HALT    | absorbing stop state, left only by reset
module legv8_control_sequencer #(
  parameter logic [63:0] PC_RESET  = 64'd0,
  parameter logic [31:0] HALT_WORD = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  output logic [63:0] pc,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  FS,
  output logic        C0,
  output logic [63:0] k,
  output logic        Bsel,
  output logic        dataMux,
  output logic        regW,
  output logic        ramW,
  output logic        ramOE,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] ir, ir_nxt;
  logic [63:0] ir_pc, ir_pc_nxt, pc_nxt;

  logic [4:0]  da_c, sa_c, sb_c, fs_c;
  logic [63:0] k_c;
  logic        c0_c, bsel_c, dmux_c, regw_c, ramw_c, ramoe_c, halted_c;

  // Only the Z flag matters to CBZ; the rest of the status bus is ignored.
  logic status_unused;
  assign status_unused = ^status[3:1];

  logic [4:0]  rd, rn, rm;
  logic [63:0] k_imm12, k_shamt, k_dt9, br_cond, br_uncond;
  logic        op_add, op_sub, op_and, op_orr, op_addi, op_subi, op_lsl;
  logic        op_ldur, op_stur, op_cbz, op_b;

  assign rd        = ir[4:0];
  assign rn        = ir[9:5];
  assign rm        = ir[20:16];
  assign k_imm12   = {52'd0, ir[21:10]};
  assign k_shamt   = {58'd0, ir[15:10]};
  assign k_dt9     = {{55{ir[20]}}, ir[20:12]};
  assign br_cond   = {{43{ir[23]}}, ir[23:5], 2'b00};
  assign br_uncond = {{36{ir[25]}}, ir[25:0], 2'b00};

  assign op_add  = (ir[31:21] == 11'b10001011000);
  assign op_sub  = (ir[31:21] == 11'b11001011000);
  assign op_and  = (ir[31:21] == 11'b10001010000);
  assign op_orr  = (ir[31:21] == 11'b10101010000);
  assign op_lsl  = (ir[31:21] == 11'b11010011011);
  assign op_ldur = (ir[31:21] == 11'b11111000010);
  assign op_stur = (ir[31:21] == 11'b11111000000);
  assign op_addi = (ir[31:22] == 10'b1001000100);
  assign op_subi = (ir[31:22] == 10'b1101000100);
  assign op_cbz  = (ir[31:24] == 8'b10110100);
  assign op_b    = (ir[31:26] == 6'b000101);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= PC_RESET;
      ir    <= '0;
      ir_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      ir_pc <= ir_pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    ir_pc_nxt = ir_pc;
    da_c      = '0;
    sa_c      = '0;
    sb_c      = '0;
    fs_c      = '0;
    k_c       = '0;
    c0_c      = 1'b0;
    bsel_c    = 1'b0;
    dmux_c    = 1'b0;
    regw_c    = 1'b0;
    ramw_c    = 1'b0;
    ramoe_c   = 1'b0;
    halted_c  = 1'b0;
    case (state)
      S_FETCH: begin
        ir_nxt    = instruction;
        ir_pc_nxt = pc;
        if (instruction == HALT_WORD) begin
          state_nxt = S_HALT;
        end else begin
          pc_nxt    = pc + 64'd4;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC, S_MEM: begin
        state_nxt = S_FETCH;
        if (op_add || op_sub || op_and || op_orr) begin
          da_c   = rd;
          sa_c   = rn;
          sb_c   = rm;
          regw_c = 1'b1;
          c0_c   = op_sub;
          fs_c   = op_add ? 5'b01000 : op_sub ? 5'b01001 : op_and ? 5'b00000 : 5'b00100;
        end else if (op_addi || op_subi) begin
          da_c   = rd;
          sa_c   = rn;
          k_c    = k_imm12;
          bsel_c = 1'b1;
          regw_c = 1'b1;
          c0_c   = op_subi;
          fs_c   = op_subi ? 5'b01001 : 5'b01000;
        end else if (op_lsl) begin
          da_c   = rd;
          sa_c   = rn;
          k_c    = k_shamt;
          bsel_c = 1'b1;
          regw_c = 1'b1;
          fs_c   = 5'b10000;
        end else if (op_ldur) begin
          // MEM repeats the address computation so RAM output stays valid for writeback.
          sa_c    = rn;
          k_c     = k_dt9;
          bsel_c  = 1'b1;
          fs_c    = 5'b01000;
          ramoe_c = 1'b1;
          if (state == S_EXEC) begin
            state_nxt = S_MEM;
          end else begin
            da_c   = rd;
            dmux_c = 1'b1;
            regw_c = 1'b1;
          end
        end else if (op_stur) begin
          sa_c   = rn;
          sb_c   = rd;
          k_c    = k_dt9;
          bsel_c = 1'b1;
          fs_c   = 5'b01000;
          ramw_c = 1'b1;
        end else if (op_cbz) begin
          sa_c   = rd;
          bsel_c = 1'b1;
          fs_c   = 5'b01000;
          if (status[0]) pc_nxt = ir_pc + br_cond;
        end else if (op_b) begin
          pc_nxt = ir_pc + br_uncond;
        end
        if (da_c == 5'd31) regw_c = 1'b0;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset blanks the control word immediately, so an aborted instruction never writes.
  assign DA      = reset ? '0 : da_c;
  assign SA      = reset ? '0 : sa_c;
  assign SB      = reset ? '0 : sb_c;
  assign FS      = reset ? '0 : fs_c;
  assign k       = reset ? '0 : k_c;
  assign C0      = !reset && c0_c;
  assign Bsel    = !reset && bsel_c;
  assign dataMux = !reset && dmux_c;
  assign regW    = !reset && regw_c;
  assign ramW    = !reset && ramw_c;
  assign ramOE   = !reset && ramoe_c;
  assign halted  = !reset && halted_c;

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Scoreboard bench: an instruction-level reference model expands each program into
// per-cycle expected control words; a negedge monitor pops and compares them.
module tb_legv8_control_sequencer;

  localparam int RSZ  = 256;
  localparam int MAXC = 1024;

  localparam int K_NOP  = 0;
  localparam int K_ADD  = 1;
  localparam int K_SUB  = 2;
  localparam int K_AND  = 3;
  localparam int K_ORR  = 4;
  localparam int K_ADDI = 5;
  localparam int K_SUBI = 6;
  localparam int K_LSL  = 7;
  localparam int K_LDUR = 8;
  localparam int K_STUR = 9;
  localparam int K_CBZ  = 10;
  localparam int K_B    = 11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction;
  logic [3:0]  status = 4'd0;
  logic [63:0] pc, k;
  logic [4:0]  DA, SA, SB, FS;
  logic        C0, Bsel, dataMux, regW, ramW, ramOE, halted;

  logic [31:0] rom [RSZ];
  logic [3:0]  st_tab [MAXC];
  bit          rst_tab [MAXC];

  typedef struct {
    logic [63:0] pc;
    bit          pc_chk;
    logic [4:0]  da, sa, sb, fs;
    logic        c0;
    logic [63:0] k;
    logic        bsel, dmux, regw, ramw, ramoe, halted;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  logic [63:0] m_pc;
  bit          m_pc_known = 1'b0;
  bit          m_halt = 1'b0;

  legv8_control_sequencer dut (
    .clock(clock), .reset(reset), .instruction(instruction), .status(status),
    .pc(pc), .DA(DA), .SA(SA), .SB(SB), .FS(FS), .C0(C0), .k(k), .Bsel(Bsel),
    .dataMux(dataMux), .regW(regW), .ramW(ramW), .ramOE(ramOE), .halted(halted)
  );

  always #5 clock = ~clock;

  assign instruction = rom[pc[9:2]];

  function automatic exp_t blank(logic [63:0] p, bit chk);
    exp_t e;
    e.pc = p; e.pc_chk = chk;
    e.da = '0; e.sa = '0; e.sb = '0; e.fs = '0; e.c0 = 1'b0; e.k = '0;
    e.bsel = 1'b0; e.dmux = 1'b0; e.regw = 1'b0; e.ramw = 1'b0; e.ramoe = 1'b0; e.halted = 1'b0;
    return e;
  endfunction

  function automatic int kind(logic [31:0] w);
    int unsigned o11 = w >> 21;
    int unsigned o10 = w >> 22;
    int unsigned o8  = w >> 24;
    int unsigned o6  = w >> 26;
    if (o11 == 'b10001011000) return K_ADD;
    if (o11 == 'b11001011000) return K_SUB;
    if (o11 == 'b10001010000) return K_AND;
    if (o11 == 'b10101010000) return K_ORR;
    if (o11 == 'b11010011011) return K_LSL;
    if (o11 == 'b11111000010) return K_LDUR;
    if (o11 == 'b11111000000) return K_STUR;
    if (o10 == 'b1001000100)  return K_ADDI;
    if (o10 == 'b1101000100)  return K_SUBI;
    if (o8  == 'b10110100)    return K_CBZ;
    if (o6  == 'b000101)      return K_B;
    return K_NOP;
  endfunction

  function automatic exp_t exec_rec(logic [31:0] w, logic [63:0] p, bit mem);
    exp_t e = blank(p, 1'b1);
    int   kd = kind(w);
    case (kd)
      K_ADD, K_SUB, K_AND, K_ORR: begin
        e.da = w[4:0]; e.sa = w[9:5]; e.sb = w[20:16]; e.regw = 1'b1;
        e.c0 = (kd == K_SUB);
        e.fs = (kd == K_ADD) ? 5'd8 : (kd == K_SUB) ? 5'd9 : (kd == K_AND) ? 5'd0 : 5'd4;
      end
      K_ADDI, K_SUBI: begin
        e.da = w[4:0]; e.sa = w[9:5]; e.k = 64'(w[21:10]); e.bsel = 1'b1; e.regw = 1'b1;
        e.c0 = (kd == K_SUBI);
        e.fs = (kd == K_SUBI) ? 5'd9 : 5'd8;
      end
      K_LSL: begin
        e.da = w[4:0]; e.sa = w[9:5]; e.k = 64'(w[15:10]); e.bsel = 1'b1; e.regw = 1'b1; e.fs = 5'd16;
      end
      K_LDUR: begin
        e.sa = w[9:5]; e.k = 64'($signed(w[20:12])); e.bsel = 1'b1; e.fs = 5'd8; e.ramoe = 1'b1;
        if (mem) begin e.da = w[4:0]; e.dmux = 1'b1; e.regw = 1'b1; end
      end
      K_STUR: begin
        e.sa = w[9:5]; e.sb = w[4:0]; e.k = 64'($signed(w[20:12])); e.bsel = 1'b1; e.fs = 5'd8; e.ramw = 1'b1;
      end
      K_CBZ: begin
        e.sa = w[4:0]; e.bsel = 1'b1; e.fs = 5'd8;
      end
      default: ;
    endcase
    if (e.da == 5'd31) e.regw = 1'b0;
    return e;
  endfunction

  // Walks the program instruction by instruction; a reset cycle aborts whatever is in flight.
  task automatic model_phase(int ncyc);
    int          c = 0;
    logic [31:0] w;
    logic [63:0] ir_pc;
    while (c < ncyc) begin
      if (rst_tab[c]) begin
        expq.push_back(blank(m_pc, m_pc_known));
        m_pc = 64'd0; m_pc_known = 1'b1; m_halt = 1'b0; c++;
        continue;
      end
      if (m_halt) begin
        exp_t e = blank(m_pc, 1'b1);
        e.halted = 1'b1;
        expq.push_back(e); c++;
        continue;
      end
      w = rom[m_pc[9:2]];
      expq.push_back(blank(m_pc, 1'b1)); c++;
      if (w == 32'h0) begin m_halt = 1'b1; continue; end
      ir_pc = m_pc;
      m_pc  = m_pc + 64'd4;
      if (c >= ncyc || rst_tab[c]) continue;
      expq.push_back(exec_rec(w, m_pc, 1'b0));
      if (kind(w) == K_CBZ && st_tab[c][0]) m_pc = ir_pc + (64'($signed(w[23:5])) << 2);
      if (kind(w) == K_B) m_pc = ir_pc + (64'($signed(w[25:0])) << 2);
      c++;
      if (kind(w) == K_LDUR && c < ncyc && !rst_tab[c]) begin
        expq.push_back(exec_rec(w, m_pc, 1'b1)); c++;
      end
    end
  endtask

  task automatic run_phase(int ncyc);
    model_phase(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      reset  = rst_tab[c];
      status = st_tab[c];
      mon_on = 1'b1;
      @(negedge clock);
      @(posedge clock); #1;
    end
    mon_on = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r   = $urandom;
    int          sel = $urandom_range(0, 12);
    int          off = int'($urandom_range(0, 16)) - 8;
    logic [18:0] o19 = off[18:0];
    logic [25:0] o26 = off[25:0];
    case (sel)
      0:  return {11'b10001011000, r[20:0]};
      1:  return {11'b11001011000, r[20:0]};
      2:  return {11'b10001010000, r[20:0]};
      3:  return {11'b10101010000, r[20:0]};
      4:  return {10'b1001000100, r[21:0]};
      5:  return {10'b1101000100, r[21:0]};
      6:  return {11'b11010011011, r[20:0]};
      7:  return {11'b11111000010, r[20:0]};
      8:  return {11'b11111000000, r[20:0]};
      9:  return {8'b10110100, o19, r[4:0]};
      10: return {6'b000101, o26};
      11: return ($urandom_range(0, 3) == 0) ? 32'h0 : r;
      default: return r;
    endcase
  endfunction

  function automatic logic [90:0] pack_exp(exp_t e);
    return {e.da, e.sa, e.sb, e.fs, e.c0, e.k, e.bsel, e.dmux, e.regw, e.ramw, e.ramoe, e.halted};
  endfunction

  always @(negedge clock) begin : monitor
    exp_t       e;
    logic [90:0] got;
    if (mon_on) begin
      got = {DA, SA, SB, FS, C0, k, Bsel, dataMux, regW, ramW, ramOE, halted};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL underflow t=%0t got ctrl %h but no expected entry", $time, got);
      end else begin
        e = expq.pop_front();
        if (got !== pack_exp(e)) begin
          errors++;
          $display("FAIL ctrl t=%0t got %h exp %h", $time, got, pack_exp(e));
        end
        if (e.pc_chk) begin
          checks++;
          if (pc !== e.pc) begin
            errors++;
            $display("FAIL pc t=%0t got %h exp %h", $time, pc, e.pc);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin st_tab[i] = 4'b0001; rst_tab[i] = 1'b0; end
    for (int i = 0; i < RSZ; i++) rom[i] = 32'h0;
    @(posedge clock); #1;

    // ADDI, SUB, CBZ taken, LDUR, ADD to XZR, HALT held, reset, restart.
    rom[0] = 32'h910017E1;
    rom[1] = 32'hCB020023;
    rom[2] = 32'hB400007F;
    rom[5] = 32'hF8408024;
    rom[6] = 32'h8B02003F;
    rom[7] = 32'h00000000;
    rst_tab[0] = 1'b1; rst_tab[1] = 1'b1; rst_tab[27] = 1'b1; rst_tab[28] = 1'b1;
    run_phase(32);

    // Same prefix with CBZ not taken, then STUR with negative offset, then HALT.
    rom[3] = 32'hF81FF025;
    rom[4] = 32'h00000000;
    for (int i = 0; i < MAXC; i++) begin st_tab[i] = 4'b0000; rst_tab[i] = 1'b0; end
    rst_tab[0] = 1'b1; rst_tab[1] = 1'b1;
    run_phase(24);

    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < RSZ; i++) rom[i] = rand_instr();
      for (int i = 0; i < MAXC; i++) begin
        st_tab[i]  = 4'($urandom);
        rst_tab[i] = ($urandom_range(0, 63) == 0);
      end
      rst_tab[0] = 1'b1; rst_tab[1] = 1'b1;
      run_phase(400);
    end

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d queued entries exp 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
